// File: rtl/acs_path_update.sv
// Add-compare-select stage of a 4-state (K=3, G0=7, G1=5) Viterbi decoder.
// Updates path metrics and survivor registers once per received symbol.
module acs_path_update #(
    parameter int unsigned METRIC_W = 4,
    parameter int unsigned PATH_W   = 8,
    parameter int unsigned PTR_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                sym_valid,
    input  logic [1:0]          sym,
    output logic [PATH_W-1:0]   updated_selected_branch_at_00,
    output logic [PATH_W-1:0]   updated_selected_branch_at_01,
    output logic [PATH_W-1:0]   updated_selected_branch_at_10,
    output logic [PATH_W-1:0]   updated_selected_branch_at_11,
    output logic [METRIC_W-1:0] new_branch_metric_00,
    output logic [METRIC_W-1:0] new_branch_metric_01,
    output logic [METRIC_W-1:0] new_branch_metric_10,
    output logic [METRIC_W-1:0] new_branch_metric_11,
    output logic [PTR_W-1:0]    write_pointer_out,
    output logic                valid_out
);

    localparam int unsigned SUM_W = METRIC_W + 1;
    localparam logic [METRIC_W-1:0] METRIC_MAX = {METRIC_W{1'b1}};

    logic [METRIC_W-1:0] metric_q [4];
    logic [METRIC_W-1:0] metric_d [4];
    logic [PATH_W-1:0]   path_q   [4];
    logic [PATH_W-1:0]   path_d   [4];
    logic [SUM_W-1:0]    sel_sum  [4];
    logic [SUM_W-1:0]    min_sum;
    logic [PTR_W-1:0]    cnt_q;
    logic [PTR_W-1:0]    wp_q;
    logic                valid_q;

    // Hamming distance between the branch label of (state s, input u) and rx.
    function automatic logic [1:0] branch_metric(input logic [1:0] s, input logic u,
                                                 input logic [1:0] rx);
        logic c0, c1;
        c0 = u ^ s[1] ^ s[0];
        c1 = u ^ s[0];
        return {1'b0, c0 ^ rx[1]} + {1'b0, c1 ^ rx[0]};
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_acs
        localparam logic [1:0] NS      = 2'(g);
        localparam logic       U       = NS[1];
        localparam logic       A       = NS[0];
        localparam logic [1:0] PRED_LO = {A, 1'b0};
        localparam logic [1:0] PRED_HI = {A, 1'b1};

        logic [SUM_W-1:0] sum_lo;
        logic [SUM_W-1:0] sum_hi;
        logic [SUM_W-1:0] norm;
        logic             take_hi;

        assign sum_lo  = {1'b0, metric_q[PRED_LO]} + SUM_W'(branch_metric(PRED_LO, U, sym));
        assign sum_hi  = {1'b0, metric_q[PRED_HI]} + SUM_W'(branch_metric(PRED_HI, U, sym));
        // Strict compare so a tie keeps the low predecessor.
        assign take_hi = sum_hi < sum_lo;

        assign sel_sum[g] = take_hi ? sum_hi : sum_lo;
        assign path_d[g]  = take_hi ? {path_q[PRED_HI][PATH_W-2:0], U}
                                    : {path_q[PRED_LO][PATH_W-2:0], U};

        assign norm        = sel_sum[g] - min_sum;
        assign metric_d[g] = (norm > SUM_W'(METRIC_MAX)) ? METRIC_MAX : norm[METRIC_W-1:0];
    end

    always_comb begin
        min_sum = sel_sum[0];
        for (int i = 1; i < 4; i++) begin
            if (sel_sum[i] < min_sum) begin
                min_sum = sel_sum[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                metric_q[i] <= (i == 0) ? '0 : METRIC_MAX;
                path_q[i]   <= '0;
            end
            cnt_q   <= '0;
            wp_q    <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < 4; i++) begin
                metric_q[i] <= (i == 0) ? '0 : METRIC_MAX;
                path_q[i]   <= '0;
            end
            cnt_q   <= '0;
            wp_q    <= '0;
            valid_q <= 1'b0;
        end else if (sym_valid) begin
            for (int i = 0; i < 4; i++) begin
                metric_q[i] <= metric_d[i];
                path_q[i]   <= path_d[i];
            end
            cnt_q   <= cnt_q + PTR_W'(1);
            wp_q    <= cnt_q;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign updated_selected_branch_at_00 = path_q[0];
    assign updated_selected_branch_at_01 = path_q[1];
    assign updated_selected_branch_at_10 = path_q[2];
    assign updated_selected_branch_at_11 = path_q[3];
    assign new_branch_metric_00          = metric_q[0];
    assign new_branch_metric_01          = metric_q[1];
    assign new_branch_metric_10          = metric_q[2];
    assign new_branch_metric_11          = metric_q[3];
    assign write_pointer_out             = wp_q;
    assign valid_out                     = valid_q;

endmodule

// File: tb/tb_acs_path_update.sv
// Bench for acs_path_update: hand vectors plus randomized runs against a trellis model.
module tb_acs_path_update;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       sym_valid;
    logic [1:0] sym;
    logic [7:0] p00, p01, p10, p11;
    logic [3:0] m00, m01, m10, m11;
    logic [2:0] wp;
    logic       vout;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int pm [4];
    int pth [4];
    int cnt;
    int mwp;
    int mvalid;

    always #5 clk = ~clk;

    acs_path_update dut (
        .clk                           (clk),
        .rst                           (rst),
        .clear                         (clear),
        .sym_valid                     (sym_valid),
        .sym                           (sym),
        .updated_selected_branch_at_00 (p00),
        .updated_selected_branch_at_01 (p01),
        .updated_selected_branch_at_10 (p10),
        .updated_selected_branch_at_11 (p11),
        .new_branch_metric_00          (m00),
        .new_branch_metric_01          (m01),
        .new_branch_metric_10          (m10),
        .new_branch_metric_11          (m11),
        .write_pointer_out             (wp),
        .valid_out                     (vout)
    );

    typedef struct {
        logic       v;
        logic       clr;
        logic [1:0] s;
        logic [3:0] m0, m1, m2, m3;
        logic [7:0] q0, q1, q2, q3;
        logic [2:0] ewp;
        logic       evo;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pm[0] = 0; pm[1] = 15; pm[2] = 15; pm[3] = 15;
        for (int i = 0; i < 4; i++) pth[i] = 0;
        cnt = 0; mwp = 0; mvalid = 0;
    endtask

    // Walk every trellis transition; ascending s with strict < keeps the low predecessor.
    task automatic model_step(input logic v, input logic c, input logic [1:0] s_in);
        int best [4];
        int from [4];
        int npth [4];
        int mn;
        if (c) begin
            model_reset();
        end else if (v) begin
            for (int i = 0; i < 4; i++) best[i] = 1000;
            for (int s = 0; s < 4; s++) begin
                for (int u = 0; u < 2; u++) begin
                    int ns, c0, c1, d;
                    ns = u * 2 + s / 2;
                    c0 = u ^ (s / 2) ^ (s % 2);
                    c1 = u ^ (s % 2);
                    d  = ((c0 != int'(s_in[1])) ? 1 : 0) + ((c1 != int'(s_in[0])) ? 1 : 0);
                    if (pm[s] + d < best[ns]) begin
                        best[ns] = pm[s] + d;
                        from[ns] = s;
                    end
                end
            end
            mn = best[0];
            for (int i = 1; i < 4; i++) if (best[i] < mn) mn = best[i];
            for (int i = 0; i < 4; i++) npth[i] = ((pth[from[i]] * 2) + i / 2) % 256;
            for (int i = 0; i < 4; i++) begin
                pm[i]  = (best[i] - mn > 15) ? 15 : best[i] - mn;
                pth[i] = npth[i];
            end
            mwp    = cnt;
            cnt    = (cnt + 1) % 8;
            mvalid = 1;
        end else begin
            mvalid = 0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_m00"}, int'(m00), pm[0]);
        chk({tag, "_m01"}, int'(m01), pm[1]);
        chk({tag, "_m10"}, int'(m10), pm[2]);
        chk({tag, "_m11"}, int'(m11), pm[3]);
        chk({tag, "_p00"}, int'(p00), pth[0]);
        chk({tag, "_p01"}, int'(p01), pth[1]);
        chk({tag, "_p10"}, int'(p10), pth[2]);
        chk({tag, "_p11"}, int'(p11), pth[3]);
        chk({tag, "_wp"}, int'(wp), mwp);
        chk({tag, "_valid"}, int'(vout), mvalid);
    endtask

    task automatic drive(input logic v, input logic c, input logic [1:0] s);
        @(negedge clk);
        sym_valid = v;
        clear     = c;
        sym       = s;
        @(posedge clk);
        #1;
        model_step(v, c, s);
    endtask

    initial begin
        int mn;
        int m [4];

        rst = 1'b1; clear = 1'b0; sym_valid = 1'b0; sym = 2'b00;
        #2;
        // Reset with no clock edge yet
        model_reset();
        chk("rst_m00", int'(m00), 0);
        chk("rst_m01", int'(m01), 15);
        chk("rst_m10", int'(m10), 15);
        chk("rst_m11", int'(m11), 15);
        chk("rst_paths", int'(p00 | p01 | p10 | p11), 0);
        chk("rst_wp", int'(wp), 0);
        chk("rst_valid", int'(vout), 0);
        @(negedge clk);
        rst = 1'b0;

        // Hand-derived vectors: single symbol, clear, codeword 1,0,1,1, idle, clear+valid
        vecs[0] = '{1'b1, 1'b0, 2'b00, 4'd0, 4'd15, 4'd2, 4'd15,
                    8'h00, 8'h00, 8'h01, 8'h01, 3'd0, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 2'b00, 4'd0, 4'd15, 4'd15, 4'd15,
                    8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 2'b11, 4'd2, 4'd15, 4'd0, 4'd15,
                    8'h00, 8'h00, 8'h01, 8'h01, 3'd0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 2'b10, 4'd3, 4'd0, 4'd3, 4'd2,
                    8'h00, 8'h02, 8'h01, 8'h03, 3'd1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 2'b00, 4'd2, 4'd3, 4'd0, 4'd3,
                    8'h04, 8'h06, 8'h05, 8'h07, 3'd2, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 2'b01, 4'd3, 4'd2, 4'd3, 4'd0,
                    8'h08, 8'h0A, 8'h09, 8'h0B, 3'd3, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 2'b10, 4'd3, 4'd2, 4'd3, 4'd0,
                    8'h08, 8'h0A, 8'h09, 8'h0B, 3'd3, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 2'b11, 4'd0, 4'd15, 4'd15, 4'd15,
                    8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 2'b00, 4'd0, 4'd15, 4'd2, 4'd15,
                    8'h00, 8'h00, 8'h01, 8'h01, 3'd0, 1'b1};

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].v, vecs[i].clr, vecs[i].s);
            chk($sformatf("vec%0d_m00", i), int'(m00), int'(vecs[i].m0));
            chk($sformatf("vec%0d_m01", i), int'(m01), int'(vecs[i].m1));
            chk($sformatf("vec%0d_m10", i), int'(m10), int'(vecs[i].m2));
            chk($sformatf("vec%0d_m11", i), int'(m11), int'(vecs[i].m3));
            chk($sformatf("vec%0d_p00", i), int'(p00), int'(vecs[i].q0));
            chk($sformatf("vec%0d_p01", i), int'(p01), int'(vecs[i].q1));
            chk($sformatf("vec%0d_p10", i), int'(p10), int'(vecs[i].q2));
            chk($sformatf("vec%0d_p11", i), int'(p11), int'(vecs[i].q3));
            chk($sformatf("vec%0d_wp", i), int'(wp), int'(vecs[i].ewp));
            chk($sformatf("vec%0d_valid", i), int'(vout), int'(vecs[i].evo));
        end

        // Pointer wrap with idle gaps
        drive(1'b0, 1'b1, 2'b00);
        check_model("wrap_clr");
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 2'($urandom));
            chk("wrap_wp_seq", int'(wp), i % 8);
            check_model("wrap_sym");
            drive(1'b0, 1'b0, 2'($urandom));
            check_model("wrap_idle");
        end

        // Randomized run with occasional idles and clears
        for (int i = 0; i < 64; i++) begin
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0), 2'($urandom));
            check_model("rand");
            if (vout) begin
                m[0] = int'(m00); m[1] = int'(m01); m[2] = int'(m10); m[3] = int'(m11);
                mn = m[0];
                for (int k = 1; k < 4; k++) if (m[k] < mn) mn = m[k];
                chk("rand_min_zero", mn, 0);
            end
        end

        // Asynchronous reset mid-stream, between clock edges
        drive(1'b1, 1'b0, 2'b10);
        drive(1'b1, 1'b0, 2'b01);
        check_model("pre_arst");
        @(negedge clk);
        sym_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_model("arst");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 2'b00);
        check_model("post_arst");
        chk("post_arst_wp", int'(wp), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/acs_path_update.md
Name: acs_path_update

Overview:
- Add-compare-select stage of the 4-state Viterbi decoder (K=3, rate 1/2, generators G0=7 octal, G1=5 octal).
- Per received symbol, computes Hamming branch metrics, updates the four path metrics with normalization, and shifts decision bits into per-state survivor registers.
- Registered outputs feed the minimum-metric selector directly downstream: survivor paths, path metrics, write pointer and valid.

Parameters:
- METRIC_W, 4, path metric width; saturating maximum is 2^METRIC_W-1.
- PATH_W, 8, survivor register width, equal to the traceback window.
- PTR_W, 3, write pointer width; the pointer wraps at 2^PTR_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- clear  in  1  synchronous restart to reset values
- sym_valid  in  1  received symbol present this cycle
- sym  in  2  received bits; sym[1]=c0 (G0), sym[0]=c1 (G1)
- updated_selected_branch_at_00/01/10/11  out  PATH_W each  survivor path per state
- new_branch_metric_00/01/10/11  out  METRIC_W each  normalized path metric per state
- write_pointer_out  out  PTR_W  window index of the symbol just incorporated
- valid_out  out  1  outputs updated this cycle

Behaviour:
- State encoding is s={u[n-1],u[n-2]}. Input u moves to ns={u,s[1]}.
- Branch outputs: c0=u^s[1]^s[0], c1=u^s[0].
- Predecessors of ns={u,a} are {a,0} (index low) and {a,1} (index high).
- Branch metric = Hamming distance of {c0,c1} to sym, range 0..2.
- ACS: both candidate sums are formed at METRIC_W+1 bits. Keep the smaller one. On a tie, select the low predecessor ({a,0}).
- Normalization: subtract the minimum of the four selected sums from each. Then saturate each result to 2^METRIC_W-1. After every update at least one metric is 0.
- Survivor update: new path[ns] = {path[selected pred][PATH_W-2:0], u}. Shift left, newest bit in the LSB, oldest bit discarded.
- All ACS work is combinational. All outputs are registered. Latency is 1 cycle: sym_valid at edge N gives updated outputs and valid_out=1 after edge N.
- valid_out is a registered copy of sym_valid, gated by clear.
- Write pointer: an internal counter starts at 0 and increments on each accepted symbol, wrapping from 2^PTR_W-1 to 0. write_pointer_out takes the counter value used by the accepted symbol, so the first symbol after reset reports 0.
- sym_valid=0: all outputs hold, and valid_out=0 next cycle.
- Reset values (rst, or clear on a clock edge):
  - new_branch_metric_00=0; _01/_10/_11=2^METRIC_W-1 (start state known to be 00).
  - All survivor paths 0.
  - Internal counter 0; write_pointer_out 0; valid_out 0.
- clear together with sym_valid: clear wins, the symbol is dropped, valid_out=0.
- rst asserted mid-stream forces reset values immediately, independent of clk.

Test Plan:
- Reset: assert rst with no clock -> metrics 0/15/15/15 (00/01/10/11), all paths 8'h00, write_pointer_out 0, valid_out 0.
- Single symbol sym=2'b00 after reset:
  - One cycle later valid_out=1 and write_pointer_out=0.
  - Metrics 00=0, 01=15, 10=2, 11=15.
  - path_00=8'h00, path_10=8'h01.
- Clean codeword for message 1,0,1,1 (symbols 11,10,00,01, back-to-back):
  - After the 4th output, new_branch_metric_11=0 and the other three metrics are at least 1.
  - updated_selected_branch_at_11[3:0]=4'b1011.
  - write_pointers seen are 0,1,2,3.
- Pointer wrap and gaps: 9 valid symbols with sym_valid idle on alternate cycles -> write_pointer_out sequence 0..7,0; outputs unchanged and valid_out=0 on idle cycles.
- Saturation/normalization: 64 random symbols -> every cycle the minimum metric is 0, no metric exceeds 15, and tie cases pick the low predecessor (checked against a reference model).
- clear mid-stream (alone, and with sym_valid=1) -> next cycle shows reset values and valid_out=0; the next symbol reports pointer 0.
